// File: rtl/segre_mem_arbiter.sv
// Shares one main-memory port between the dcache and icache miss paths.
// Dirty dcache victims are written back before the refill read; simultaneous misses alternate.
module segre_mem_arbiter #(
    parameter int ADDR_SIZE  = 32,
    parameter int LANE_SIZE  = 128,
    parameter int BYTE_SIZE  = 4,
    parameter int INDEX_SIZE = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dc_miss_i,
    input  logic [ADDR_SIZE-1:0]  dc_addr_i,
    input  logic                  dc_writeback_i,
    input  logic [ADDR_SIZE-1:0]  dc_wb_addr_i,
    input  logic [LANE_SIZE-1:0]  dc_wb_data_i,
    input  logic [INDEX_SIZE-1:0] dc_lru_index_i,
    output logic                  dc_data_rdy_o,
    output logic [LANE_SIZE-1:0]  dc_data_o,
    output logic [INDEX_SIZE-1:0] dc_lru_index_o,
    input  logic                  ic_miss_i,
    input  logic [ADDR_SIZE-1:0]  ic_addr_i,
    input  logic [INDEX_SIZE-1:0] ic_lru_index_i,
    output logic                  ic_data_rdy_o,
    output logic [LANE_SIZE-1:0]  ic_data_o,
    output logic [INDEX_SIZE-1:0] ic_lru_index_o,
    output logic                  mm_rd_o,
    output logic                  mm_wr_o,
    output logic [ADDR_SIZE-1:0]  mm_addr_o,
    output logic [LANE_SIZE-1:0]  mm_wr_data_o,
    input  logic [LANE_SIZE-1:0]  mm_rd_data_i,
    input  logic                  mm_rd_valid_i,
    input  logic                  mm_wr_ack_i
);

    typedef enum logic [2:0] {IDLE, DC_WB, DC_REQ, DC_WAIT, IC_REQ, IC_WAIT} state_t;

    localparam logic [ADDR_SIZE-1:0] LOW_MASK = ADDR_SIZE'((1 << BYTE_SIZE) - 1);

    state_t                state_q;
    logic                  last_ic_q;
    logic [ADDR_SIZE-1:0]  req_addr_q;
    logic                  dc_rdy_q, ic_rdy_q;
    logic [LANE_SIZE-1:0]  dc_data_q, ic_data_q;
    logic [INDEX_SIZE-1:0] dc_lru_q, ic_lru_q;
    logic                  mm_rd_q, mm_wr_q;
    logic [ADDR_SIZE-1:0]  mm_addr_q;
    logic [LANE_SIZE-1:0]  mm_wr_data_q;

    function automatic logic [ADDR_SIZE-1:0] align(input logic [ADDR_SIZE-1:0] a);
        return a & ~LOW_MASK;
    endfunction

    // A requester whose refill is being returned this cycle is not eligible again.
    logic dc_elig, ic_elig, grant_dc, grant_ic;
    assign dc_elig  = dc_miss_i & ~dc_rdy_q;
    assign ic_elig  = ic_miss_i & ~ic_rdy_q;
    assign grant_dc = dc_elig & (~ic_elig | last_ic_q);
    assign grant_ic = ic_elig & (~dc_elig | ~last_ic_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_ic_q    <= 1'b1;
            req_addr_q   <= '0;
            dc_rdy_q     <= 1'b0;
            ic_rdy_q     <= 1'b0;
            dc_data_q    <= '0;
            ic_data_q    <= '0;
            dc_lru_q     <= '0;
            ic_lru_q     <= '0;
            mm_rd_q      <= 1'b0;
            mm_wr_q      <= 1'b0;
            mm_addr_q    <= '0;
            mm_wr_data_q <= '0;
        end else begin
            dc_rdy_q <= 1'b0;
            ic_rdy_q <= 1'b0;
            mm_rd_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_dc) begin
                        last_ic_q  <= 1'b0;
                        req_addr_q <= align(dc_addr_i);
                        dc_lru_q   <= dc_lru_index_i;
                        if (dc_writeback_i) begin
                            state_q      <= DC_WB;
                            mm_wr_q      <= 1'b1;
                            mm_addr_q    <= align(dc_wb_addr_i);
                            mm_wr_data_q <= dc_wb_data_i;
                        end else begin
                            state_q   <= DC_REQ;
                            mm_rd_q   <= 1'b1;
                            mm_addr_q <= align(dc_addr_i);
                        end
                    end else if (grant_ic) begin
                        last_ic_q  <= 1'b1;
                        req_addr_q <= align(ic_addr_i);
                        ic_lru_q   <= ic_lru_index_i;
                        state_q    <= IC_REQ;
                        mm_rd_q    <= 1'b1;
                        mm_addr_q  <= align(ic_addr_i);
                    end
                end
                DC_WB: begin
                    // The refill read is issued on the cycle right after the write ack.
                    if (mm_wr_ack_i) begin
                        state_q      <= DC_REQ;
                        mm_wr_q      <= 1'b0;
                        mm_wr_data_q <= '0;
                        mm_rd_q      <= 1'b1;
                        mm_addr_q    <= req_addr_q;
                    end
                end
                DC_REQ: begin
                    state_q   <= DC_WAIT;
                    mm_addr_q <= '0;
                end
                IC_REQ: begin
                    state_q   <= IC_WAIT;
                    mm_addr_q <= '0;
                end
                DC_WAIT: begin
                    if (mm_rd_valid_i) begin
                        state_q   <= IDLE;
                        dc_data_q <= mm_rd_data_i;
                        dc_rdy_q  <= 1'b1;
                    end
                end
                IC_WAIT: begin
                    if (mm_rd_valid_i) begin
                        state_q   <= IDLE;
                        ic_data_q <= mm_rd_data_i;
                        ic_rdy_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dc_data_rdy_o  = dc_rdy_q;
    assign dc_data_o      = dc_data_q;
    assign dc_lru_index_o = dc_lru_q;
    assign ic_data_rdy_o  = ic_rdy_q;
    assign ic_data_o      = ic_data_q;
    assign ic_lru_index_o = ic_lru_q;
    assign mm_rd_o        = mm_rd_q;
    assign mm_wr_o        = mm_wr_q;
    assign mm_addr_o      = mm_addr_q;
    assign mm_wr_data_o   = mm_wr_data_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: each scenario task drives the miss and memory
// handshakes cycle by cycle and compares outputs against hand-computed values.
module tb_segre_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         dc_miss, dc_wb;
    logic [31:0]  dc_addr, dc_wb_addr;
    logic [127:0] dc_wb_data;
    logic [1:0]   dc_lru_i;
    logic         dc_rdy;
    logic [127:0] dc_data;
    logic [1:0]   dc_lru_o;
    logic         ic_miss;
    logic [31:0]  ic_addr;
    logic [1:0]   ic_lru_i;
    logic         ic_rdy;
    logic [127:0] ic_data;
    logic [1:0]   ic_lru_o;
    logic         mm_rd, mm_wr;
    logic [31:0]  mm_addr;
    logic [127:0] mm_wr_data;
    logic [127:0] mm_rd_data;
    logic         mm_rd_valid, mm_wr_ack;

    int pass_cnt = 0;
    int total    = 0;

    localparam logic [127:0] LANE_A5 = {16{8'hA5}};
    localparam logic [127:0] LANE_DE = {8{16'hDEAD}};
    localparam logic [127:0] LANE_11 = {16{8'h11}};
    localparam logic [127:0] LANE_22 = {16{8'h22}};
    localparam logic [127:0] LANE_33 = {16{8'h33}};

    segre_mem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .dc_miss_i(dc_miss), .dc_addr_i(dc_addr), .dc_writeback_i(dc_wb),
        .dc_wb_addr_i(dc_wb_addr), .dc_wb_data_i(dc_wb_data), .dc_lru_index_i(dc_lru_i),
        .dc_data_rdy_o(dc_rdy), .dc_data_o(dc_data), .dc_lru_index_o(dc_lru_o),
        .ic_miss_i(ic_miss), .ic_addr_i(ic_addr), .ic_lru_index_i(ic_lru_i),
        .ic_data_rdy_o(ic_rdy), .ic_data_o(ic_data), .ic_lru_index_o(ic_lru_o),
        .mm_rd_o(mm_rd), .mm_wr_o(mm_wr), .mm_addr_o(mm_addr), .mm_wr_data_o(mm_wr_data),
        .mm_rd_data_i(mm_rd_data), .mm_rd_valid_i(mm_rd_valid), .mm_wr_ack_i(mm_wr_ack)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the REQ cycle; leaves the bench in the cycle where rdy should be high.
    task automatic mem_return(input logic [127:0] data, input int lat);
        repeat (lat) step();
        mm_rd_valid = 1'b1;
        mm_rd_data  = data;
        step();
        mm_rd_valid = 1'b0;
        mm_rd_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        dc_miss = 0; dc_wb = 0; dc_addr = 0; dc_wb_addr = 0; dc_wb_data = 0; dc_lru_i = 0;
        ic_miss = 0; ic_addr = 0; ic_lru_i = 0;
        mm_rd_data = 0; mm_rd_valid = 0; mm_wr_ack = 0;
        do_reset();
        total++; if ({mm_rd, mm_wr, mm_addr} !== 34'd0) $display("FAIL reset_mm_ctrl: got %h exp 0", {mm_rd, mm_wr, mm_addr}); else pass_cnt++;
        total++; if (mm_wr_data !== 128'd0) $display("FAIL reset_wr_data: got %h exp 0", mm_wr_data); else pass_cnt++;
        total++; if ({dc_rdy, ic_rdy, dc_lru_o, ic_lru_o} !== 6'd0) $display("FAIL reset_rdy_lru: got %h exp 0", {dc_rdy, ic_rdy, dc_lru_o, ic_lru_o}); else pass_cnt++;
        total++; if ({dc_data, ic_data} !== 256'd0) $display("FAIL reset_data: got %h exp 0", {dc_data, ic_data}); else pass_cnt++;
    endtask

    task automatic test_clean_dc();
        dc_miss = 1; dc_addr = 32'h0000_1234; dc_wb = 0; dc_lru_i = 2'd3;
        step();
        total++; if (mm_rd !== 1'b1) $display("FAIL clean_rd: got %0b exp 1", mm_rd); else pass_cnt++;
        total++; if (mm_addr !== 32'h0000_1230) $display("FAIL clean_addr: got %h exp 00001230", mm_addr); else pass_cnt++;
        total++; if (mm_wr !== 1'b0) $display("FAIL clean_no_wr: got %0b exp 0", mm_wr); else pass_cnt++;
        step();
        total++; if ({mm_rd, mm_addr} !== 33'd0) $display("FAIL clean_rd_pulse: got %h exp 0", {mm_rd, mm_addr}); else pass_cnt++;
        mem_return(LANE_A5, 2);
        total++; if (dc_rdy !== 1'b1) $display("FAIL clean_rdy: got %0b exp 1", dc_rdy); else pass_cnt++;
        total++; if (dc_data !== LANE_A5) $display("FAIL clean_data: got %h exp %h", dc_data, LANE_A5); else pass_cnt++;
        total++; if (dc_lru_o !== 2'd3) $display("FAIL clean_lru: got %0d exp 3", dc_lru_o); else pass_cnt++;
        // miss still high during the rdy cycle must not cause a second grant
        step();
        dc_miss = 0;
        total++; if ({dc_rdy, mm_rd} !== 2'b00) $display("FAIL clean_no_regrant: got %b exp 00", {dc_rdy, mm_rd}); else pass_cnt++;
        total++; if (dc_data !== LANE_A5) $display("FAIL clean_data_hold: got %h exp %h", dc_data, LANE_A5); else pass_cnt++;
        step();
    endtask

    task automatic test_dirty_dc();
        dc_miss = 1; dc_wb = 1; dc_wb_addr = 32'h0000_0080; dc_wb_data = LANE_DE; dc_addr = 32'h0000_0040;
        mm_rd_valid = 1'b1;  // stray valid while idle/WB must be ignored
        step();
        mm_rd_valid = 1'b0;
        total++; if ({mm_wr, mm_rd} !== 2'b10) $display("FAIL dirty_wr: got %b exp 10", {mm_wr, mm_rd}); else pass_cnt++;
        total++; if (mm_addr !== 32'h0000_0080) $display("FAIL dirty_wb_addr: got %h exp 00000080", mm_addr); else pass_cnt++;
        total++; if (mm_wr_data !== LANE_DE) $display("FAIL dirty_wb_data: got %h exp %h", mm_wr_data, LANE_DE); else pass_cnt++;
        dc_wb = 0; dc_wb_data = '0;
        step();
        step();
        total++; if ({mm_wr, mm_rd, mm_addr} !== {2'b10, 32'h80}) $display("FAIL dirty_wr_held: got %h exp 200000080", {mm_wr, mm_rd, mm_addr}); else pass_cnt++;
        mm_wr_ack = 1'b1;
        step();
        mm_wr_ack = 1'b0;
        total++; if ({mm_wr, mm_rd} !== 2'b01) $display("FAIL dirty_rd_after_ack: got %b exp 01", {mm_wr, mm_rd}); else pass_cnt++;
        total++; if (mm_addr !== 32'h0000_0040) $display("FAIL dirty_rd_addr: got %h exp 00000040", mm_addr); else pass_cnt++;
        mem_return(LANE_11, 1);
        total++; if ({dc_rdy, dc_data} !== {1'b1, LANE_11}) $display("FAIL dirty_rdy: got %h exp 1%h", {dc_rdy, dc_data}, LANE_11); else pass_cnt++;
        dc_miss = 0;
        step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        dc_miss = 1; dc_addr = 32'h0000_0100; ic_miss = 1; ic_addr = 32'h0000_0200;
        step();
        total++; if ({mm_rd, mm_addr} !== {1'b1, 32'h100}) $display("FAIL sim_first_dc: got %h exp 100000100", {mm_rd, mm_addr}); else pass_cnt++;
        mem_return(LANE_22, 1);
        total++; if ({dc_rdy, ic_rdy} !== 2'b10) $display("FAIL sim_dc_rdy: got %b exp 10", {dc_rdy, ic_rdy}); else pass_cnt++;
        dc_miss = 0;
        step();
        total++; if ({mm_rd, mm_addr} !== {1'b1, 32'h200}) $display("FAIL sim_then_ic: got %h exp 100000200", {mm_rd, mm_addr}); else pass_cnt++;
        mem_return(LANE_33, 2);
        total++; if ({ic_rdy, ic_data} !== {1'b1, LANE_33}) $display("FAIL sim_ic_rdy: got %h exp 1%h", {ic_rdy, ic_data}, LANE_33); else pass_cnt++;
        ic_miss = 0;
        step();
        // a lone DC transfer makes DC the last grant, so the next tie goes to IC
        dc_miss = 1; dc_addr = 32'h0000_0300;
        step();
        mem_return(LANE_11, 1);
        dc_miss = 0;
        step();
        dc_miss = 1; dc_addr = 32'h0000_0500; ic_miss = 1; ic_addr = 32'h0000_0400;
        step();
        total++; if ({mm_rd, mm_addr} !== {1'b1, 32'h400}) $display("FAIL sim_alternate_ic: got %h exp 100000400", {mm_rd, mm_addr}); else pass_cnt++;
        mem_return(LANE_22, 1);
        ic_miss = 0;
        step();
        total++; if ({mm_rd, mm_addr} !== {1'b1, 32'h500}) $display("FAIL sim_alternate_dc: got %h exp 100000500", {mm_rd, mm_addr}); else pass_cnt++;
        mem_return(LANE_33, 1);
        dc_miss = 0;
        step();
    endtask

    task automatic test_ic_mid_transfer();
        int rd_seen;
        dc_miss = 1; dc_addr = 32'h0000_0600;
        step();
        step();
        ic_miss = 1; ic_addr = 32'h0000_0700; ic_lru_i = 2'd1;
        rd_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mm_rd) rd_seen++;
        end
        total++; if (rd_seen != 0) $display("FAIL mid_no_ic_rd: got %0d rd pulses exp 0", rd_seen); else pass_cnt++;
        mm_rd_valid = 1'b1; mm_rd_data = LANE_A5;
        step();
        mm_rd_valid = 1'b0;
        total++; if ({dc_rdy, mm_rd} !== 2'b10) $display("FAIL mid_dc_rdy: got %b exp 10", {dc_rdy, mm_rd}); else pass_cnt++;
        dc_miss = 0;
        step();
        total++; if ({mm_rd, mm_addr} !== {1'b1, 32'h700}) $display("FAIL mid_ic_grant: got %h exp 100000700", {mm_rd, mm_addr}); else pass_cnt++;
        mem_return(LANE_DE, 1);
        ic_miss = 0;
        step();
    endtask

    task automatic test_reset_mid();
        ic_miss = 1; ic_addr = 32'h0000_0800;
        step();
        step();
        rst = 1'b1; ic_miss = 0;
        step();
        rst = 1'b0;
        total++; if ({mm_rd, mm_wr, mm_addr, ic_rdy, dc_rdy} !== 36'd0) $display("FAIL rstmid_ctrl: got %h exp 0", {mm_rd, mm_wr, mm_addr, ic_rdy, dc_rdy}); else pass_cnt++;
        mm_rd_valid = 1'b1; mm_rd_data = LANE_A5;
        step();
        mm_rd_valid = 1'b0; mm_rd_data = '0;
        step();
        total++; if ({ic_rdy, ic_data} !== 129'd0) $display("FAIL rstmid_stray: got %h exp 0", {ic_rdy, ic_data}); else pass_cnt++;
        ic_miss = 1; ic_addr = 32'h0000_08F4;
        step();
        total++; if ({mm_rd, mm_addr} !== {1'b1, 32'h8F0}) $display("FAIL rstmid_idle_grant: got %h exp 1000008f0", {mm_rd, mm_addr}); else pass_cnt++;
        mem_return(LANE_11, 1);
        ic_miss = 0;
        step();
    endtask

    task automatic test_lru();
        ic_miss = 1; ic_addr = 32'h0000_0900; ic_lru_i = 2'd2;
        step();
        ic_lru_i = 2'd1;
        mem_return(LANE_22, 3);
        total++; if ({ic_rdy, ic_lru_o} !== 3'b110) $display("FAIL lru_ic: got %b exp 110", {ic_rdy, ic_lru_o}); else pass_cnt++;
        total++; if (ic_data !== LANE_22) $display("FAIL lru_ic_data: got %h exp %h", ic_data, LANE_22); else pass_cnt++;
        ic_miss = 0;
        step();
        step();
        total++; if (ic_lru_o !== 2'd2) $display("FAIL lru_ic_hold: got %0d exp 2", ic_lru_o); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clean_dc();
        test_dirty_dc();
        test_simultaneous();
        test_ic_mid_transfer();
        test_reset_mid();
        test_lru();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", pass_cnt, total);
        $fatal(1);
    end

endmodule
